link_table_arbiter: RTL and testbench
=====================================

Name: link_table_arbiter

Overview:
Shares one link-table manager among NUM_REQ requesters.
- Arbitrates requesters round-robin and captures the winner's order.
- Issues the order to the manager, waits for its result and routes the result back to the winner.
- Only one order is in flight at a time. A watchdog converts a hung order into an error response.

Parameters:
NUM_REQ, 4, number of requesters (2..16, need not be a power of 2)
ADDR_WIDTH, 16, node index width
DATA_WIDTH, 16, data width
TABLE_WIDTH, 8, table index width
TIMEOUT, 1023, max cycles in WAIT before error response (>=1)
(ID_WIDTH = $clog2(NUM_REQ), local)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester order valid
req_busy  out  NUM_REQ  per-requester busy; transfer = valid && !busy
req_type  in  2*NUM_REQ  packed order type, requester i at [2i+1:2i]
req_table  in  TABLE_WIDTH*NUM_REQ  packed table index
req_node  in  ADDR_WIDTH*NUM_REQ  packed node index
req_data  in  DATA_WIDTH*NUM_REQ  packed write data
rsp_valid  out  NUM_REQ  per-requester response valid
rsp_busy  in  NUM_REQ  per-requester response busy
rsp_data  out  DATA_WIDTH  response data (shared)
rsp_err  out  1  response is a timeout
rsp_id  out  ID_WIDTH  requester being answered
mgr_order_valid  out  1  order valid to manager
mgr_order_busy  in  1  manager busy
mgr_order_type  out  2  order type
mgr_order_table  out  TABLE_WIDTH  table index
mgr_order_node  out  ADDR_WIDTH  node index
mgr_order_data  out  DATA_WIDTH  data
mgr_dout_valid  in  1  manager result valid
mgr_dout_busy  out  1  result busy to manager
mgr_dout_data  in  DATA_WIDTH  manager result
txn_active  out  1  high in any state but IDLE

Behaviour:
- Reset values:
  - req_busy all 1; rsp_valid 0; rsp_data/rsp_err/rsp_id 0.
  - mgr_order_valid 0; all mgr_order_* 0; mgr_dout_busy 0.
  - rr_ptr 0; state IDLE; wdog 0.
  - Reset mid-transaction abandons it; the manager is not notified.
- All outputs are registered. No combinational input-to-output paths.
- IDLE: if |req_valid, select the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ-1 -> 0. Register it as g, clear req_busy[g], go ACCEPT.
- ACCEPT:
  - req_valid[g]=1 (transfer): capture type/table/node/data, req_busy <= all 1, mgr_order_valid <= 1, go ISSUE. Capture to mgr_order_valid latency is 1 cycle.
  - req_valid[g]=0 (withdrawn): req_busy <= all 1, go IDLE, rr_ptr unchanged.
- ISSUE: hold mgr_order_* stable. When !mgr_order_busy: mgr_order_valid <= 0, wdog <= 0, go WAIT.
- WAIT:
  - mgr_dout_valid (busy is 0): rsp_data <= mgr_dout_data, rsp_err <= 0, rsp_id <= g, rsp_valid[g] <= 1, mgr_dout_busy <= 1, go RETURN.
  - Else wdog increments. On wdog == TIMEOUT-1: rsp_data <= 0, rsp_err <= 1, rsp_valid[g] <= 1, go RETURN.
  - A result arriving on the same cycle as the timeout wins (rsp_err 0).
- RETURN: when !rsp_busy[g]: rsp_valid <= 0, mgr_dout_busy <= 0, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1, go IDLE.
- mgr_dout_busy is 1 only in RETURN. Any result handshake completed outside WAIT (stale or late) is discarded silently.
- Only one bit of rsp_valid is set at a time. req_busy has at most one bit low.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

Decomposition:
- Shared package link_table_pkg:
  - order type codes APPE=2'b00, DELE=2'b01, CHAG=2'b10, READ=2'b11.
  - arbiter state encoding IDLE/ACCEPT/ISSUE/WAIT/RETURN.
- Sub-module link_table_rr_pick: combinational round-robin picker. Inputs: request vector and rr_ptr. Outputs: any-hit and winner index.
- FSM, capture registers and watchdog live in link_table_arbiter.

Test Plan:
- Single request: req 1 READ table 3 node 2 -> mgr_order_* = {READ,3,2}. Manager returns 0x00AB -> rsp_valid[1]=1, rsp_data=0x00AB, rsp_id=1, rsp_err=0, then rr_ptr=2.
- All four requesters valid continuously, ten orders -> grant order 0,1,2,3,0,1,2,3,0,1; never two rsp_valid bits set.
- Backpressure: mgr_order_busy held 1 for 5 cycles in ISSUE -> mgr_order fields unchanged. rsp_busy[g] held 3 cycles -> rsp_data stable, mgr_dout_busy=1 throughout.
- Timeout with TIMEOUT=8 and manager silent -> rsp_valid[g] 8 cycles after ISSUE transfer, rsp_data=0, rsp_err=1. A late result arriving in IDLE is discarded.
- Withdrawal: req_valid[2] drops in ACCEPT -> back to IDLE, no mgr_order_valid, rr_ptr unchanged.
- rst pulsed during WAIT -> next cycle all outputs at reset values, txn_active=0.

Source files
------------

// File: rtl/link_table_pkg.sv
// Shared types for the link-table arbiter.
//   order_e : order type codes carried on req_type / mgr order_type
//   state_e : arbiter FSM state encoding
package link_table_pkg;

  typedef enum logic [1:0] {
    OrdAppe = 2'b00,
    OrdDele = 2'b01,
    OrdChag = 2'b10,
    OrdRead = 2'b11
  } order_e;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StIssue,
    StWait,
    StReturn
  } state_e;

endpackage

// File: rtl/link_table_arbiter_if.sv
// Manager-side bus of the link-table arbiter: order channel out, result channel back.
//   master : arbiter side (drives order_*, dout_busy)
//   slave  : manager side (drives order_busy, dout_valid, dout_data)
interface link_table_arbiter_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TABLE_WIDTH = 8
);
  logic                   order_valid;
  logic                   order_busy;
  logic [1:0]             order_type;
  logic [TABLE_WIDTH-1:0] order_table;
  logic [ADDR_WIDTH-1:0]  order_node;
  logic [DATA_WIDTH-1:0]  order_data;
  logic                   dout_valid;
  logic                   dout_busy;
  logic [DATA_WIDTH-1:0]  dout_data;

  modport master (
    output order_valid, order_type, order_table, order_node, order_data, dout_busy,
    input  order_busy, dout_valid, dout_data
  );

  modport slave (
    input  order_valid, order_type, order_table, order_node, order_data, dout_busy,
    output order_busy, dout_valid, dout_data
  );
endinterface

// File: rtl/link_table_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   hit : any request set
//   idx : first set request scanning ptr, ptr+1, ... with wrap
module link_table_rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                hit,
  output logic [ID_WIDTH-1:0] idx
);
  int unsigned cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!hit && req[cand[ID_WIDTH-1:0]]) begin
        hit = 1'b1;
        idx = cand[ID_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/link_table_arbiter.sv
// Shares one link-table manager among NUM_REQ requesters, one order in flight.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/busy/...    : per-requester order channels (packed fields)
//   rsp_valid/busy/...    : per-requester response; data/err/id shared
//   mgr                   : manager order and result channels
//   txn_active            : FSM not idle
module link_table_arbiter
  import link_table_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TABLE_WIDTH = 8,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_busy,
  input  logic [2*NUM_REQ-1:0]           req_type,
  input  logic [TABLE_WIDTH*NUM_REQ-1:0] req_table,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_node,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_busy,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  link_table_arbiter_if.master           mgr,
  output logic                           txn_active
);
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    g_q, g_d, rr_ptr_q, rr_ptr_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic [NUM_REQ-1:0]     req_busy_q, req_busy_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
  logic                   ord_valid_q, ord_valid_d;
  logic [1:0]             ord_type_q, ord_type_d;
  logic [TABLE_WIDTH-1:0] ord_table_q, ord_table_d;
  logic [ADDR_WIDTH-1:0]  ord_node_q, ord_node_d;
  logic [DATA_WIDTH-1:0]  ord_data_q, ord_data_d;
  logic                   dout_busy_q, dout_busy_d;

  logic                   pick_hit;
  logic [ID_WIDTH-1:0]    pick_idx;
  logic [1:0]             sel_type;
  logic [TABLE_WIDTH-1:0] sel_table;
  logic [ADDR_WIDTH-1:0]  sel_node;
  logic [DATA_WIDTH-1:0]  sel_data;

  function automatic logic [NUM_REQ-1:0] to_onehot(logic [ID_WIDTH-1:0] idx);
    to_onehot      = '0;
    to_onehot[idx] = 1'b1;
  endfunction

  link_table_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Unpack the granted requester's order fields.
  always_comb begin
    sel_type  = '0;
    sel_table = '0;
    sel_node  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g_q == ID_WIDTH'(i)) begin
        sel_type  = req_type[2*i +: 2];
        sel_table = req_table[TABLE_WIDTH*i +: TABLE_WIDTH];
        sel_node  = req_node[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_data  = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    req_busy_d  = req_busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    ord_valid_d = ord_valid_q;
    ord_type_d  = ord_type_q;
    ord_table_d = ord_table_q;
    ord_node_d  = ord_node_q;
    ord_data_d  = ord_data_q;
    dout_busy_d = dout_busy_q;
    case (state_q)
      StIdle: begin
        if (pick_hit) begin
          g_d        = pick_idx;
          req_busy_d = ~to_onehot(pick_idx);
          state_d    = StAccept;
        end
      end
      StAccept: begin
        req_busy_d = '1;
        if (req_valid[g_q]) begin
          ord_type_d  = sel_type;
          ord_table_d = sel_table;
          ord_node_d  = sel_node;
          ord_data_d  = sel_data;
          ord_valid_d = 1'b1;
          state_d     = StIssue;
        end else begin
          // Withdrawn: rr_ptr stays so the same scan order applies next time.
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (!mgr.order_busy) begin
          ord_valid_d = 1'b0;
          wdog_d      = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A result on the timeout cycle takes priority over the error.
        if (mgr.dout_valid) begin
          rsp_data_d  = mgr.dout_data;
          rsp_err_d   = 1'b0;
          rsp_id_d    = g_q;
          rsp_valid_d = to_onehot(g_q);
          dout_busy_d = 1'b1;
          state_d     = StReturn;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = g_q;
          rsp_valid_d = to_onehot(g_q);
          state_d     = StReturn;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StReturn: begin
        if (!rsp_busy[g_q]) begin
          rsp_valid_d = '0;
          dout_busy_d = 1'b0;
          rr_ptr_d    = (g_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      req_busy_q  <= '1;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      ord_valid_q <= 1'b0;
      ord_type_q  <= '0;
      ord_table_q <= '0;
      ord_node_q  <= '0;
      ord_data_q  <= '0;
      dout_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      req_busy_q  <= req_busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      ord_valid_q <= ord_valid_d;
      ord_type_q  <= ord_type_d;
      ord_table_q <= ord_table_d;
      ord_node_q  <= ord_node_d;
      ord_data_q  <= ord_data_d;
      dout_busy_q <= dout_busy_d;
    end
  end

  assign req_busy        = req_busy_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_id          = rsp_id_q;
  assign mgr.order_valid = ord_valid_q;
  assign mgr.order_type  = ord_type_q;
  assign mgr.order_table = ord_table_q;
  assign mgr.order_node  = ord_node_q;
  assign mgr.order_data  = ord_data_q;
  assign mgr.dout_busy   = dout_busy_q;
  assign txn_active      = (state_q != StIdle);
endmodule

// File: tb/tb_link_table_arbiter.sv
// Directed bench for link_table_arbiter (NUM_REQ=4, TIMEOUT=8).
module tb_link_table_arbiter;
  import link_table_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid, req_busy, rsp_valid, rsp_busy;
  logic [7:0]  req_type;
  logic [31:0] req_table;
  logic [63:0] req_node, req_data;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  rsp_id;
  logic        txn_active;

  int checks = 0;
  int failures = 0;

  link_table_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TABLE_WIDTH(8)) mgr_if ();

  link_table_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .TABLE_WIDTH(8), .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_busy   (req_busy),
    .req_type   (req_type),
    .req_table  (req_table),
    .req_node   (req_node),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_busy   (rsp_busy),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_id     (rsp_id),
    .mgr        (mgr_if),
    .txn_active (txn_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; req_type = '0; req_table = '0; req_node = '0; req_data = '0;
    rsp_busy = '0;
    mgr_if.order_busy = 1'b0; mgr_if.dout_valid = 1'b0; mgr_if.dout_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_busy !== 4'b1111) begin
      failures++; $display("FAIL reset_req_busy got %b exp 1111", req_busy);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_err, rsp_id} !== 23'd0) begin
      failures++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_data, rsp_err, rsp_id});
    end
    checks++;
    if ({mgr_if.order_valid, mgr_if.order_type, mgr_if.order_table, mgr_if.order_node,
         mgr_if.order_data, mgr_if.dout_busy} !== 44'd0) begin
      failures++; $display("FAIL reset_mgr got %h exp 0", {mgr_if.order_valid, mgr_if.order_type,
        mgr_if.order_table, mgr_if.order_node, mgr_if.order_data, mgr_if.dout_busy});
    end
    checks++;
    if (txn_active !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL reset_state got act=%b ptr=%0d exp 0 0", txn_active, dut.rr_ptr_q);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0010;
    req_type[3:2] = OrdRead;
    req_table[15:8] = 8'd3;
    req_node[31:16] = 16'd2;
    step();  // -> ACCEPT
    checks++;
    if (req_busy !== 4'b1101 || txn_active !== 1'b1) begin
      failures++; $display("FAIL single_accept got busy=%b act=%b exp 1101 1", req_busy, txn_active);
    end
    step();  // -> ISSUE
    checks++;
    if ({mgr_if.order_valid, mgr_if.order_type, mgr_if.order_table, mgr_if.order_node,
         mgr_if.order_data} !== {1'b1, 2'b11, 8'd3, 16'd2, 16'd0}) begin
      failures++; $display("FAIL single_order got %h exp %h", {mgr_if.order_valid,
        mgr_if.order_type, mgr_if.order_table, mgr_if.order_node, mgr_if.order_data},
        {1'b1, 2'b11, 8'd3, 16'd2, 16'd0});
    end
    checks++;
    if (req_busy !== 4'b1111) begin
      failures++; $display("FAIL single_busy_restore got %b exp 1111", req_busy);
    end
    req_valid = '0;
    step();  // -> WAIT
    checks++;
    if (mgr_if.order_valid !== 1'b0) begin
      failures++; $display("FAIL single_order_drop got %b exp 0", mgr_if.order_valid);
    end
    mgr_if.dout_valid = 1'b1;
    mgr_if.dout_data = 16'h00AB;
    step();  // -> RETURN
    mgr_if.dout_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err, mgr_if.dout_busy} !==
        {4'b0010, 16'h00AB, 2'd1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL single_rsp got %h exp %h",
        {rsp_valid, rsp_data, rsp_id, rsp_err, mgr_if.dout_busy},
        {4'b0010, 16'h00AB, 2'd1, 1'b0, 1'b1});
    end
    step();  // -> IDLE
    checks++;
    if (rsp_valid !== 4'b0 || mgr_if.dout_busy !== 1'b0 || txn_active !== 1'b0 ||
        dut.rr_ptr_q !== 2'd2) begin
      failures++; $display("FAIL single_done got rv=%b db=%b act=%b ptr=%0d exp 0000 0 0 2",
        rsp_valid, mgr_if.dout_busy, txn_active, dut.rr_ptr_q);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    apply_reset();
    req_valid = 4'b1111;
    mgr_if.dout_valid = 1'b1;
    mgr_if.dout_data = 16'h0C0C;
    seen = 0;
    for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
      step();
      if (rsp_valid !== 4'b0) begin
        checks++;
        if (rsp_id !== 2'(seen % 4) || rsp_valid !== (4'b0001 << (seen % 4))) begin
          failures++; $display("FAIL rr_grant_%0d got id=%0d rv=%b exp id=%0d", seen, rsp_id,
            rsp_valid, seen % 4);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 10) begin
      failures++; $display("FAIL rr_count got %0d exp 10", seen);
    end
    req_valid = '0;
    mgr_if.dout_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    mgr_if.order_busy = 1'b1;
    req_valid = 4'b0001;
    req_type[1:0] = OrdChag;
    req_table[7:0] = 8'h05;
    req_node[15:0] = 16'h1234;
    req_data[15:0] = 16'hBEEF;
    step();  // -> ACCEPT
    step();  // -> ISSUE
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({mgr_if.order_valid, mgr_if.order_type, mgr_if.order_table, mgr_if.order_node,
           mgr_if.order_data} !== {1'b1, 2'b10, 8'h05, 16'h1234, 16'hBEEF}) begin
        failures++; $display("FAIL bp_order_hold_%0d got %h exp %h", i, {mgr_if.order_valid,
          mgr_if.order_type, mgr_if.order_table, mgr_if.order_node, mgr_if.order_data},
          {1'b1, 2'b10, 8'h05, 16'h1234, 16'hBEEF});
      end
    end
    mgr_if.order_busy = 1'b0;
    step();  // -> WAIT
    checks++;
    if (mgr_if.order_valid !== 1'b0) begin
      failures++; $display("FAIL bp_order_release got %b exp 0", mgr_if.order_valid);
    end
    mgr_if.dout_valid = 1'b1;
    mgr_if.dout_data = 16'h5A5A;
    rsp_busy = 4'b0001;
    step();  // -> RETURN
    mgr_if.dout_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rsp_valid, rsp_data, mgr_if.dout_busy} !== {4'b0001, 16'h5A5A, 1'b1}) begin
        failures++; $display("FAIL bp_rsp_hold_%0d got %h exp %h", i,
          {rsp_valid, rsp_data, mgr_if.dout_busy}, {4'b0001, 16'h5A5A, 1'b1});
      end
      step();
    end
    rsp_busy = '0;
    step();  // -> IDLE
    checks++;
    if (rsp_valid !== 4'b0 || mgr_if.dout_busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
      failures++; $display("FAIL bp_done got rv=%b db=%b ptr=%0d exp 0000 0 1", rsp_valid,
        mgr_if.dout_busy, dut.rr_ptr_q);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_valid = 4'b1000;
    step();  // -> ACCEPT
    step();  // -> ISSUE
    req_valid = '0;
    step();  // order transfer, -> WAIT
    for (int k = 1; k < 8; k++) begin
      step();
      checks++;
      if (rsp_valid !== 4'b0) begin
        failures++; $display("FAIL to_early_%0d got %b exp 0000", k, rsp_valid);
      end
    end
    step();
    checks++;
    if ({rsp_valid, rsp_data, rsp_err, rsp_id} !== {4'b1000, 16'h0, 1'b1, 2'd3}) begin
      failures++; $display("FAIL to_rsp got %h exp %h", {rsp_valid, rsp_data, rsp_err, rsp_id},
        {4'b1000, 16'h0, 1'b1, 2'd3});
    end
    step();  // -> IDLE
    mgr_if.dout_valid = 1'b1;
    mgr_if.dout_data = 16'h7777;
    step();
    mgr_if.dout_valid = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0 || txn_active !== 1'b0 || mgr_if.dout_busy !== 1'b0 ||
        rsp_data !== 16'h0 || dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL to_late_discard got rv=%b act=%b db=%b d=%h ptr=%0d exp 0 0 0 0 0",
        rsp_valid, txn_active, mgr_if.dout_busy, rsp_data, dut.rr_ptr_q);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    req_valid = 4'b0100;
    step();  // -> ACCEPT
    checks++;
    if (req_busy !== 4'b1011) begin
      failures++; $display("FAIL wd_accept got %b exp 1011", req_busy);
    end
    req_valid = '0;
    step();  // -> IDLE
    checks++;
    if (req_busy !== 4'b1111 || mgr_if.order_valid !== 1'b0 || txn_active !== 1'b0 ||
        dut.rr_ptr_q !== 2'd0) begin
      failures++; $display("FAIL wd_idle got busy=%b ov=%b act=%b ptr=%0d exp 1111 0 0 0",
        req_busy, mgr_if.order_valid, txn_active, dut.rr_ptr_q);
    end
    step();
    checks++;
    if (mgr_if.order_valid !== 1'b0) begin
      failures++; $display("FAIL wd_no_order got %b exp 0", mgr_if.order_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    req_valid = 4'b0100;
    req_data[47:32] = 16'hCAFE;
    step(); step();
    req_valid = '0;
    step();  // WAIT
    mgr_if.dout_valid = 1'b1;
    mgr_if.dout_data = 16'h1111;
    step();  // RETURN
    mgr_if.dout_valid = 1'b0;
    step();  // IDLE, rr_ptr 3
    req_valid = 4'b0010;  // scan 3,0,1 -> requester 1
    req_table[15:8] = 8'h44;
    req_node[31:16] = 16'h9999;
    step(); step();
    req_valid = '0;
    step();  // WAIT
    checks++;
    if (txn_active !== 1'b1 || rsp_data !== 16'h1111 || mgr_if.order_table !== 8'h44) begin
      failures++; $display("FAIL rw_pre got act=%b d=%h t=%h exp 1 1111 44", txn_active,
        rsp_data, mgr_if.order_table);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({req_busy, rsp_valid, rsp_data, rsp_err, rsp_id, txn_active} !==
        {4'b1111, 4'b0, 16'h0, 1'b0, 2'd0, 1'b0}) begin
      failures++; $display("FAIL rw_req_rsp got %h exp %h",
        {req_busy, rsp_valid, rsp_data, rsp_err, rsp_id, txn_active},
        {4'b1111, 4'b0, 16'h0, 1'b0, 2'd0, 1'b0});
    end
    checks++;
    if ({mgr_if.order_valid, mgr_if.order_type, mgr_if.order_table, mgr_if.order_node,
         mgr_if.order_data, mgr_if.dout_busy} !== 44'd0) begin
      failures++; $display("FAIL rw_mgr got %h exp 0", {mgr_if.order_valid, mgr_if.order_type,
        mgr_if.order_table, mgr_if.order_node, mgr_if.order_data, mgr_if.dout_busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_withdraw();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
